// File: rtl/pc_file.sv
// pc_file: circular store of per-fetch-bundle state (PC, history, BP info,
// branch position), indexed by FetchID. Fetch allocates at wrPtr, the ROB
// frees entries by advancing its committed FetchID, and a taken branch
// rewinds wrPtr to just past the redirecting bundle.

package pc_file_pkg;
   typedef logic [2:0] FetchID_t;

   typedef struct packed {
      logic [30:0] pc;
      logic [7:0]  hist;
      logic [3:0]  bpi;
      logic [2:0]  branchPos;
   } PCFileEntry;

   typedef struct packed {
      logic        taken;
      FetchID_t    fetchID;
      logic [31:0] dstPC;
   } BranchProv;
endpackage

module pc_file
   import pc_file_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int NUM_READ    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       IN_alloc,
   input  PCFileEntry IN_allocData,
   output FetchID_t   OUT_allocID,
   output logic       OUT_full,
   input  FetchID_t   IN_comFetchID,
   input  BranchProv  IN_branch,
   input  FetchID_t   IN_readAddr [NUM_READ],
   output PCFileEntry OUT_readData [NUM_READ],
   output logic       OUT_overflow
);

   FetchID_t   wr_ptr_q, wr_ptr_d;
   logic       overflow_q, overflow_d;
   logic       alloc_ok;
   PCFileEntry entries_q [NUM_ENTRIES];

   // The slot at the committed FetchID is still live, so equality means full.
   assign OUT_full     = (wr_ptr_q == IN_comFetchID);
   assign OUT_allocID  = wr_ptr_q;
   assign OUT_overflow = overflow_q;

   // An allocation is accepted only with a free slot and no redirect.
   assign alloc_ok = IN_alloc && !OUT_full && !IN_branch.taken;

   // Next-state for the write pointer and the sticky overflow flag.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;
      if (IN_branch.taken) begin
         wr_ptr_d = IN_branch.fetchID + FetchID_t'(1);
      end else if (IN_alloc) begin
         if (OUT_full) overflow_d = 1'b1;
         else          wr_ptr_d   = wr_ptr_q + FetchID_t'(1);
      end
   end

   // Pointer and overflow registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry array is not reset; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (alloc_ok && rst) entries_q[wr_ptr_q] <= IN_allocData;
   end

   // Combinational read ports without write bypass.
   generate
      for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
         assign OUT_readData[gi] = entries_q[IN_readAddr[gi]];
      end
   endgenerate

endmodule

// File: tb/tb_pc_file.sv
// tb_pc_file: directed stimulus against pc_file with a behavioural model
// (live-range arithmetic on integers plus a shadow array) checked every
// cycle at the falling edge, plus literal expectations at key points.

module tb_pc_file;
   import pc_file_pkg::*;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       IN_alloc = 1'b0;
   PCFileEntry IN_allocData = '0;
   FetchID_t   OUT_allocID;
   logic       OUT_full;
   FetchID_t   IN_comFetchID = 3'd7;
   BranchProv  IN_branch = '0;
   FetchID_t   IN_readAddr [2];
   PCFileEntry OUT_readData [2];
   logic       OUT_overflow;

   int checks = 0;
   int failures = 0;

   pc_file #(.NUM_ENTRIES(N), .NUM_READ(2)) dut (
      .clk(clk), .rst(rst),
      .IN_alloc(IN_alloc), .IN_allocData(IN_allocData),
      .OUT_allocID(OUT_allocID), .OUT_full(OUT_full),
      .IN_comFetchID(IN_comFetchID), .IN_branch(IN_branch),
      .IN_readAddr(IN_readAddr), .OUT_readData(OUT_readData),
      .OUT_overflow(OUT_overflow)
   );

   always #5 clk = ~clk;

   // Behavioural model: integer write position, sticky overflow, shadow array.
   int         m_wr = 0;
   bit         m_ovf = 0;
   PCFileEntry m_mem [N];
   bit         m_valid [N];

   function automatic int free_slots(int wr, int com);
      return (com - wr + N) % N;
   endfunction

   function automatic PCFileEntry mk(input logic [30:0] pc);
      PCFileEntry e;
      e.pc        = pc;
      e.hist      = pc[7:0] ^ 8'h5A;
      e.bpi       = pc[3:0] + 4'd1;
      e.branchPos = pc[2:0] ^ 3'd5;
      return e;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_wr  = 0;
         m_ovf = 0;
      end else if (IN_branch.taken) begin
         m_wr = (int'(IN_branch.fetchID) + 1) % N;
      end else if (IN_alloc) begin
         if (free_slots(m_wr, int'(IN_comFetchID)) == 0) m_ovf = 1;
         else begin
            m_mem[m_wr]   = IN_allocData;
            m_valid[m_wr] = 1;
            m_wr          = (m_wr + 1) % N;
         end
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst) begin
         check("allocID", longint'(OUT_allocID), longint'(m_wr));
         check("full", longint'(OUT_full),
               longint'(free_slots(m_wr, int'(IN_comFetchID)) == 0));
         check("overflow", longint'(OUT_overflow), longint'(m_ovf));
         for (int k = 0; k < 2; k++) begin
            if (m_valid[IN_readAddr[k]])
               check($sformatf("rd%0d", k), longint'(OUT_readData[k]),
                     longint'(m_mem[IN_readAddr[k]]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input logic [30:0] pc);
      IN_alloc     = 1'b1;
      IN_allocData = mk(pc);
      step();
      IN_alloc     = 1'b0;
   endtask

   initial begin
      IN_readAddr[0] = '0;
      IN_readAddr[1] = '0;
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      #12;
      check("rst_allocID", longint'(OUT_allocID), 0);
      check("rst_full", longint'(OUT_full), 0);
      check("rst_ovf", longint'(OUT_overflow), 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Fill to capacity with committed pointer at 7.
      for (int i = 0; i < 7; i++) begin
         check($sformatf("fill_id%0d", i), longint'(OUT_allocID), longint'(i));
         do_alloc(31'h100 + 31'(i));
      end
      check("fill_full", longint'(OUT_full), 1);
      IN_readAddr[0] = 3'd6; #1;
      check("fill_slot6", longint'(OUT_readData[0].pc), 'h106);
      do_alloc(31'h777);
      check("drop_ovf", longint'(OUT_overflow), 1);
      check("drop_id", longint'(OUT_allocID), 7);

      // Asynchronous reset mid-cycle.
      #2 rst = 1'b0;
      #1;
      check("arst_id", longint'(OUT_allocID), 0);
      check("arst_full", longint'(OUT_full), 0);
      check("arst_ovf", longint'(OUT_overflow), 0);
      step();
      rst = 1'b1;

      // Read-after-write and same-cycle read of the slot being written.
      for (int i = 0; i < 3; i++) do_alloc(31'h300 + 31'(i));
      IN_readAddr[0] = 3'd3;
      IN_alloc       = 1'b1;
      IN_allocData   = mk(31'h1000);
      #1;
      check("rdw_old", longint'(OUT_readData[0].pc), 'h103);
      step();
      IN_alloc = 1'b0;
      check("raw_new", longint'(OUT_readData[0].pc), 'h1000);
      do_alloc(31'h304);

      // Redirect with a concurrent allocation.
      check("br_pre_id", longint'(OUT_allocID), 5);
      IN_branch.taken   = 1'b1;
      IN_branch.fetchID = 3'd2;
      IN_alloc          = 1'b1;
      IN_allocData      = mk(31'hDEAD);
      step();
      IN_branch.taken = 1'b0;
      IN_alloc        = 1'b0;
      IN_readAddr[1]  = 3'd5;
      #1;
      check("br_id", longint'(OUT_allocID), 3);
      check("br_slot5", longint'(OUT_readData[1].pc), 'h105);
      check("br_ovf", longint'(OUT_overflow), 0);

      // Wrap-around with committed pointer at 5.
      IN_branch.taken   = 1'b1;
      IN_branch.fetchID = 3'd5;
      step();
      IN_branch.taken = 1'b0;
      IN_comFetchID   = 3'd5;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("wrap_id%0d", i), longint'(OUT_allocID), longint'((6 + i) % 8));
         do_alloc(31'h2000 + 31'((6 + i) % 8));
      end
      check("wrap_full", longint'(OUT_full), 1);
      IN_comFetchID = 3'd6;
      #1;
      check("wrap_unfull", longint'(OUT_full), 0);

      // Independent dual reads.
      IN_readAddr[0] = 3'd1;
      IN_readAddr[1] = 3'd4;
      #1;
      check("dual_rd0", longint'(OUT_readData[0].pc), 'h2001);
      check("dual_rd1", longint'(OUT_readData[1].pc), 'h2004);
      check("dual_rd1_bpi", longint'(OUT_readData[1].bpi), 5);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/pc_file.md
Name: pc_file

Overview:
- Circular store of per-fetch-bundle state: bundle PC, global branch history, branch-prediction info and predicted branch position.
- Indexed by FetchID and sits between the fetch stage and the ROB.
- Fetch allocates one entry per fetched bundle and receives the FetchID to tag its uops.
- The ROB reads an entry back at commit to rebuild full PCs, histories and BP updates. Entries are reclaimed as the ROB's committed FetchID advances; on a branch redirect, younger entries are discarded.

Parameters:
- NUM_ENTRIES, 8, number of bundle slots; must equal 2**$bits(FetchID_t).
- NUM_READ, 2, combinational read ports. Port 0 is the ROB commit lookup; port 1 is the branch unit.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- IN_alloc  in  1  fetch requests a new entry this cycle.
- IN_allocData  in  $bits(PCFileEntry)  {pc[30:0], hist, bpi, branchPos} for the new bundle.
- OUT_allocID  out  $bits(FetchID_t)  FetchID the next accepted allocation receives (= wrPtr).
- OUT_full  out  1  no free slot; an allocation this cycle is dropped.
- IN_comFetchID  in  $bits(FetchID_t)  FetchID of the most recently committed uop (ROB curFetchID).
- IN_branch  in  $bits(BranchProv)  redirect; uses .taken and .fetchID.
- IN_readAddr[NUM_READ]  in  $bits(FetchID_t) each  read addresses.
- OUT_readData[NUM_READ]  out  $bits(PCFileEntry) each  read data.
- OUT_overflow  out  1  sticky: an allocation was attempted while full.

Behaviour:
- State: wrPtr ($bits(FetchID_t) bits), entry array, overflow flag.
- Reset (rst=0, asynchronous):
  - wrPtr=0, overflow=0.
  - Array contents are not reset.
  - OUT_allocID=0, OUT_full=0 (given IN_comFetchID = all-ones, the ROB's reset value), OUT_overflow=0.
  - Reset may assert mid-operation; all state returns to these values immediately, with no partial write.
- Live range:
  - The entry at IN_comFetchID is still live, because its bundle may contain uncommitted uops.
  - Entries from IN_comFetchID+1 up to wrPtr-1 (mod NUM_ENTRIES) are live.
  - Usable capacity is NUM_ENTRIES-1.
- OUT_full = (wrPtr == IN_comFetchID). This is combinational from registered wrPtr and the input.
- OUT_allocID = wrPtr, combinational.
- Allocation (cycle t):
  - If IN_alloc && !OUT_full && !IN_branch.taken: array[wrPtr] <= IN_allocData and wrPtr <= wrPtr+1, wrapping modulo NUM_ENTRIES.
  - The new data is readable from t+1.
- Full with IN_alloc: no write, wrPtr unchanged, overflow <= 1. overflow is cleared only by reset.
- Branch redirect:
  - If IN_branch.taken: wrPtr <= IN_branch.fetchID+1 (mod). Entry IN_branch.fetchID is kept.
  - A same-cycle alloc is dropped. It does not set overflow and does not write the array.
- Reads:
  - Combinational: OUT_readData[k] = array[IN_readAddr[k]], with no latency.
  - No write-to-read bypass. A read of the slot being written in the same cycle returns the old contents.
  - Reads of non-live slots return stale data; this is not an error.
- Commit pointer:
  - IN_comFetchID is consumed combinationally only.
  - The ROB moves it monotonically forward; backward movement is not checked.
- Wrap-around: all pointer arithmetic is modulo NUM_ENTRIES. There is no extra wrap bit; fullness comes solely from equality with IN_comFetchID.
- Simultaneous alloc and commit-pointer advance in one cycle: OUT_full is evaluated against the current IN_comFetchID, so a slot freed this cycle is usable this cycle.

Test Plan:
- Reset then 7 allocs with IN_comFetchID=7:
  - OUT_allocID steps 0..6 and the 7th alloc lands in slot 6.
  - After 7 allocs wrPtr=7, so OUT_full=1.
  - An 8th alloc is dropped and OUT_overflow=1.
- Reset mid-operation:
  - Full, overflow=1, then rst=0 → wrPtr=0, OUT_full=0, OUT_overflow=0 asynchronously, without waiting for a clock edge.
- Alloc pc=0x1000 into slot 3, next cycle IN_readAddr[0]=3 → OUT_readData[0].pc=0x1000 in the same cycle. A same-cycle read of slot 3 during its write returns the prior value.
- Branch redirect:
  - wrPtr=5, IN_branch.taken with fetchID=2, plus IN_alloc=1 → next wrPtr=3, no write to slot 5, overflow unchanged.
- Wrap:
  - IN_comFetchID=5, allocs from wrPtr=6 → IDs 6, 7, 0, 1, 2, 3, 4.
  - OUT_full=1 at wrPtr=5.
  - Advancing IN_comFetchID to 6 clears OUT_full in the same cycle.
- Dual read: IN_readAddr[0]=1 and IN_readAddr[1]=4 concurrently → both ports return independent correct entries.
